tausworthe_multi: RTL and testbench

TAUSWORTHE_MULTI -- requirements
Module: tausworthe_multi

---
 rtl/tausworthe_multi.sv | 116 +++++++++++
 tb/tb_tausworthe_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tausworthe_multi.sv
// Multi-channel three-component Tausworthe uniform generator with a valid/ready hold register,
// single-shot or continuous triggering and per-component runtime seeding.
module tausworthe_multi #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              en_in,
  input  logic              mode_cont,
  input  logic              out_ready,
  input  logic              seed_load,
  input  logic [2:0]        seed_ch,
  input  logic [1:0]        seed_sel,
  input  logic [31:0]       seed_data,
  output logic              out_valid,
  output logic [CH*N-1:0]   urng_out,
  output logic [31:0]       sample_cnt
);

  typedef enum logic [0:0] {StIdle, StValid} state_e;

  state_e        state_q;
  logic          en_prev_q;
  logic [31:0]   s0_q  [CH];
  logic [31:0]   s1_q  [CH];
  logic [31:0]   s2_q  [CH];
  logic [31:0]   s0_nx [CH];
  logic [31:0]   s1_nx [CH];
  logic [31:0]   s2_nx [CH];
  logic [31:0]   mix   [CH];
  logic [CH*N-1:0] sample;
  logic          start;
  logic          step;
  logic          accept;

  function automatic logic [31:0] chan_offset(input logic [31:0] base, input int k);
    return base + (32'(k) << 24);
  endfunction

  function automatic logic [31:0] step0(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  always_comb begin
    sample = '0;
    for (int k = 0; k < int'(CH); k++) begin
      s0_nx[k] = step0(s0_q[k]);
      s1_nx[k] = step1(s1_q[k]);
      s2_nx[k] = step2(s2_q[k]);
      mix[k]   = s0_nx[k] ^ s1_nx[k] ^ s2_nx[k];
      sample[k*N +: N] = mix[k][N-1:0];
    end
  end

  // Single-shot mode triggers only on the rising edge of the request.
  assign start  = mode_cont ? en_in : (en_in & ~en_prev_q);
  assign accept = (state_q == StValid) & out_ready;
  assign step   = ~seed_load &
                  ((state_q == StIdle) ? start : (out_ready & mode_cont & en_in));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= StIdle;
      out_valid  <= 1'b0;
      urng_out   <= '0;
      sample_cnt <= '0;
      en_prev_q  <= 1'b0;
      for (int k = 0; k < int'(CH); k++) begin
        s0_q[k] <= chan_offset(32'h00FF_FFFF, k);
        s1_q[k] <= chan_offset(32'h00CC_CCCC, k);
        s2_q[k] <= chan_offset(32'h00FF_00FF, k);
      end
    end else begin
      en_prev_q <= en_in;
      if (accept) begin
        sample_cnt <= sample_cnt + 32'd1;
      end
      if (step) begin
        state_q   <= StValid;
        out_valid <= 1'b1;
        urng_out  <= sample;
        for (int k = 0; k < int'(CH); k++) begin
          s0_q[k] <= s0_nx[k];
          s1_q[k] <= s1_nx[k];
          s2_q[k] <= s2_nx[k];
        end
      end else if (accept) begin
        state_q   <= StIdle;
        out_valid <= 1'b0;
      end
      // Step is suppressed during seed writes, so these never race the step update.
      if (seed_load) begin
        for (int k = 0; k < int'(CH); k++) begin
          if (seed_ch == 3'(k)) begin
            case (seed_sel)
              2'd0: s0_q[k] <= (seed_data < 32'd2)  ? chan_offset(32'h00FF_FFFF, k) : seed_data;
              2'd1: s1_q[k] <= (seed_data < 32'd8)  ? chan_offset(32'h00CC_CCCC, k) : seed_data;
              2'd2: s2_q[k] <= (seed_data < 32'd16) ? chan_offset(32'h00FF_00FF, k) : seed_data;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tausworthe_multi.sv
// Self-checking bench for tausworthe_multi: directed scenarios followed by random traffic,
// all compared cycle by cycle against a behavioural reference model.
module tb_tausworthe_multi;

  localparam int unsigned N  = 8;
  localparam int unsigned CH = 2;

  logic            clk = 1'b0;
  logic            reset_in = 1'b1;
  logic            en_in = 1'b0;
  logic            mode_cont = 1'b0;
  logic            out_ready = 1'b0;
  logic            seed_load = 1'b0;
  logic [2:0]      seed_ch = 3'd0;
  logic [1:0]      seed_sel = 2'd3;
  logic [31:0]     seed_data = 32'd0;
  logic            out_valid;
  logic [CH*N-1:0] urng_out;
  logic [31:0]     sample_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]     m_s [3][CH];
  bit              m_valid;
  logic [CH*N-1:0] m_out;
  logic [31:0]     m_cnt;
  bit              m_prev;

  tausworthe_multi #(.N(N), .CH(CH)) dut (
    .clk_in     (clk),
    .reset_in   (reset_in),
    .en_in      (en_in),
    .mode_cont  (mode_cont),
    .out_ready  (out_ready),
    .seed_load  (seed_load),
    .seed_ch    (seed_ch),
    .seed_sel   (seed_sel),
    .seed_data  (seed_data),
    .out_valid  (out_valid),
    .urng_out   (urng_out),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input int c, input int k);
    logic [31:0] base;
    case (c)
      0:       base = 32'h00FF_FFFF;
      1:       base = 32'h00CC_CCCC;
      default: base = 32'h00FF_00FF;
    endcase
    return base + 32'h0100_0000 * k;
  endfunction

  function automatic logic [31:0] adv(input int c, input logic [31:0] s);
    case (c)
      0:       return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
      1:       return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
      default: return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endcase
  endfunction

  function automatic logic [31:0] min_seed(input int c);
    case (c)
      0:       return 32'd2;
      1:       return 32'd8;
      default: return 32'd16;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge given the inputs presented at that edge.
  task automatic model_edge(input int rst, input int en, input int mode, input int rdy,
                            input int sl, input int sch, input int ssel,
                            input logic [31:0] sdata);
    bit start, go;
    logic [31:0] w;
    if (rst != 0) begin
      m_valid = 0; m_out = '0; m_cnt = 0; m_prev = 0;
      for (int k = 0; k < int'(CH); k++)
        for (int c = 0; c < 3; c++) m_s[c][k] = dflt(c, k);
      return;
    end
    start = (mode != 0) ? (en != 0) : ((en != 0) && !m_prev);
    go = 0;
    if (!m_valid) begin
      go = start && (sl == 0);
    end else if (rdy != 0) begin
      m_cnt = m_cnt + 1;
      go = (mode != 0) && (en != 0) && (sl == 0);
      if (!go) m_valid = 0;
    end
    if (go) begin
      m_valid = 1;
      for (int k = 0; k < int'(CH); k++) begin
        w = 0;
        for (int c = 0; c < 3; c++) begin
          m_s[c][k] = adv(c, m_s[c][k]);
          w = w ^ m_s[c][k];
        end
        m_out[k*N +: N] = w[N-1:0];
      end
    end
    if (sl != 0 && ssel < 3 && sch < int'(CH))
      m_s[ssel][sch] = (sdata < min_seed(ssel)) ? dflt(ssel, sch) : sdata;
    m_prev = (en != 0);
  endtask

  task automatic cyc(input int rst, input int en, input int mode, input int rdy, input int sl,
                     input int sch, input int ssel, input logic [31:0] sdata, input string tag);
    reset_in  = (rst != 0);
    en_in     = (en != 0);
    mode_cont = (mode != 0);
    out_ready = (rdy != 0);
    seed_load = (sl != 0);
    seed_ch   = 3'(sch);
    seed_sel  = 2'(ssel);
    seed_data = sdata;
    model_edge(rst, en, mode, rdy, sl, sch, ssel, sdata);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, ".urng"}, 32'(urng_out), 32'(m_out));
    check({tag, ".cnt"}, sample_cnt, m_cnt);
  endtask

  initial begin
    int acc;
    logic [31:0] cnt0;
    int rst, en, mode, rdy, sl, sch, ssel;
    logic [31:0] sd;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 3, 0, "reset");
    cyc(1, 0, 0, 0, 0, 0, 3, 0, "reset2");

    // One-cycle pulse, single-shot, consumer always ready
    cyc(0, 1, 0, 1, 0, 0, 3, 0, "pulse");
    check("first_sample", {24'd0, urng_out[7:0]}, 32'h81);
    check("ch1_differs", {31'd0, urng_out[15:8] != urng_out[7:0]}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 3, 0, "pulse_acc");
    check("cnt_one", sample_cnt, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 3, 0, "pulse_idle");

    // Single-shot with en held high yields one sample only
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 0, 0, 3, 0, "held");
    cyc(0, 0, 0, 1, 0, 0, 3, 0, "held_rel");
    check("held_cnt", sample_cnt, 32'd2);

    // Seed write below minimum falls back to default
    cyc(1, 0, 0, 0, 0, 0, 3, 0, "rst_seed");
    cyc(0, 0, 0, 1, 1, 0, 0, 32'd0, "seed_s0_zero");
    cyc(0, 1, 0, 1, 0, 0, 3, 0, "seed_pulse");
    check("seed_zero_sample", {24'd0, urng_out[7:0]}, 32'h81);
    cyc(0, 0, 0, 1, 0, 0, 3, 0, "seed_acc");
    cyc(0, 0, 0, 1, 1, 0, 1, 32'h1234_5678, "seed_s1");
    cyc(0, 1, 0, 1, 0, 0, 3, 0, "seed_s1_pulse");
    cyc(0, 0, 0, 1, 0, 0, 3, 0, "seed_s1_acc");

    // Reset while holding an unaccepted sample
    cyc(1, 0, 0, 0, 0, 0, 3, 0, "rst_hold");
    cyc(0, 1, 0, 0, 0, 0, 3, 0, "hold_start");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 3, 0, "hold");
    cyc(1, 0, 0, 0, 0, 0, 3, 0, "rst_in_valid");
    check("rst_urng_zero", 32'(urng_out), 32'd0);
    check("rst_cnt_zero", sample_cnt, 32'd0);
    cyc(0, 1, 0, 1, 0, 0, 3, 0, "restart");
    check("restart_sample", {24'd0, urng_out[7:0]}, 32'h81);

    // Continuous with ready toggling
    cnt0 = sample_cnt;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && (i % 2 == 0)) acc++;
      cyc(0, 1, 1, (i % 2 == 0) ? 1 : 0, 0, 0, 3, 0, "cont_toggle");
    end
    check("cont_cnt", sample_cnt - cnt0, 32'(acc));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0) ? 1 : 0;
      mode = ($urandom_range(0, 9) != 0) ? 1 : 0;
      en   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rdy  = int'($urandom_range(0, 1));
      sl   = ($urandom_range(0, 9) == 0) ? 1 : 0;
      sch  = int'($urandom_range(0, 7));
      ssel = int'($urandom_range(0, 3));
      sd   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      cyc(rst, en, mode, rdy, sl, sch, ssel, sd, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
